// File: rtl/ccm_arb_ctrl.sv
// Single-port closely-coupled memory shared by fetch (I) and load/store (D).
// Optional starvation guard for the I port: define CCM_STARVE_GUARD_EN.
module ccm_arb_ctrl #(
   parameter int DEPTH      = 4096,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   output logic                i_rsp_valid,
   output logic [DATA_W-1:0]   i_rsp_data,
   output logic                i_rsp_err,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic                d_req_we,
   input  logic [DATA_W/8-1:0] d_req_be,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_rdata,
   output logic                d_rsp_err
);
   localparam int BW    = DATA_W / 8;
   localparam int OFF_W = $clog2(BW);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0]  i_idx, d_idx;
   logic              i_oor, d_oor, i_mis, i_bad;
   logic              i_gnt, d_gnt, force_i;
   logic              d_lsb_unused;

   logic              i_rsp_valid_q, d_rsp_valid_q;
   logic              i_rsp_err_q, i_rsp_err_d;
   logic              d_rsp_err_q, d_rsp_err_d;
   logic [DATA_W-1:0] i_rsp_data_q, i_rsp_data_d;
   logic [DATA_W-1:0] d_rsp_data_q, d_rsp_data_d;

   assign i_idx = i_req_addr[OFF_W +: IDX_W];
   assign d_idx = d_req_addr[OFF_W +: IDX_W];
   assign i_oor = |(i_req_addr >> (OFF_W + IDX_W));
   assign d_oor = |(d_req_addr >> (OFF_W + IDX_W));
   assign i_mis = |i_req_addr[OFF_W-1:0];
   assign i_bad = i_oor || i_mis;
   assign d_lsb_unused = ^d_req_addr[OFF_W-1:0];

`ifdef CCM_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign force_i = i_req_valid && (cnt_q == CNT_W'(STARVE_MAX));

   always_comb begin
      cnt_d = '0;
      if (i_req_valid && !i_gnt)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   // Guard compiled out: D always wins.
   assign force_i = (STARVE_MAX < 0);
`endif

   assign d_gnt = !rst && d_req_valid && !force_i;
   assign i_gnt = !rst && i_req_valid && (!d_req_valid || force_i);

   assign i_req_ready = i_gnt;
   assign d_req_ready = d_gnt;

   // Array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (d_gnt && d_req_we && !d_oor) begin
         for (int k = 0; k < BW; k++) begin
            if (d_req_be[k])
               mem_q[d_idx][8*k +: 8] <= d_req_wdata[8*k +: 8];
         end
      end
   end

   always_comb begin
      i_rsp_data_d = i_rsp_data_q;
      i_rsp_err_d  = i_rsp_err_q;
      d_rsp_data_d = d_rsp_data_q;
      d_rsp_err_d  = d_rsp_err_q;
      if (i_gnt) begin
         i_rsp_err_d  = i_bad;
         i_rsp_data_d = i_bad ? '0 : mem_q[i_idx];
      end
      if (d_gnt) begin
         d_rsp_err_d  = d_oor;
         d_rsp_data_d = (d_oor || d_req_we) ? '0 : mem_q[d_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_rsp_valid_q <= 1'b0;
         i_rsp_err_q   <= 1'b0;
         i_rsp_data_q  <= '0;
         d_rsp_valid_q <= 1'b0;
         d_rsp_err_q   <= 1'b0;
         d_rsp_data_q  <= '0;
      end else begin
         i_rsp_valid_q <= i_gnt;
         i_rsp_err_q   <= i_rsp_err_d;
         i_rsp_data_q  <= i_rsp_data_d;
         d_rsp_valid_q <= d_gnt;
         d_rsp_err_q   <= d_rsp_err_d;
         d_rsp_data_q  <= d_rsp_data_d;
      end
   end

   assign i_rsp_valid = i_rsp_valid_q;
   assign i_rsp_data  = i_rsp_data_q;
   assign i_rsp_err   = i_rsp_err_q;
   assign d_rsp_valid = d_rsp_valid_q;
   assign d_rsp_rdata = d_rsp_data_q;
   assign d_rsp_err   = d_rsp_err_q;
endmodule

// File: tb/tb_ccm_arb_ctrl.sv
// Bench for ccm_arb_ctrl: word-array model plus directed vectors.
module tb_ccm_arb_ctrl;
   localparam int DEPTH = 4096;
   localparam int SM    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        i_req_ready;
   logic [31:0] i_req_addr = '0;
   logic        i_rsp_valid;
   logic [31:0] i_rsp_data;
   logic        i_rsp_err;
   logic        d_req_valid = 1'b0;
   logic        d_req_ready;
   logic        d_req_we = 1'b0;
   logic [3:0]  d_req_be = '0;
   logic [31:0] d_req_addr = '0;
   logic [31:0] d_req_wdata = '0;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_rdata;
   logic        d_rsp_err;

   ccm_arb_ctrl #(
      .DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32), .STARVE_MAX(SM)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
      .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .i_rsp_err(i_rsp_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
      .d_req_we(d_req_we), .d_req_be(d_req_be),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
      .d_rsp_err(d_rsp_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // Reference model: word array, lost-cycle count, expected responses
   logic [31:0] mm [int];
   int          lost = 0;
   logic        e_iv = 0, e_ie = 0, e_dv = 0, e_de = 0;
   logic [31:0] e_id = '0, e_dd = '0;
   logic [31:0] ma, mo;
   bit          mgi, mgd;

   function automatic bit m_force();
`ifdef CCM_STARVE_GUARD_EN
      return i_req_valid && (lost >= SM);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_gd();
      return !rst && d_req_valid && !m_force();
   endfunction

   function automatic bit m_gi();
      return !rst && i_req_valid && (m_force() || !d_req_valid);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_iv = 0; e_ie = 0; e_id = '0;
         e_dv = 0; e_de = 0; e_dd = '0;
         lost = 0;
      end else begin
         mgi = m_gi();
         mgd = m_gd();
         if (i_req_valid && !mgi) lost = lost + 1;
         else lost = 0;
         e_iv = mgi;
         e_dv = mgd;
         if (mgi) begin
            ma = i_req_addr;
            if (ma >= 4 * DEPTH || ma % 4 != 0) begin
               e_ie = 1; e_id = '0;
            end else begin
               e_ie = 0;
               e_id = mm.exists(ma / 4) ? mm[ma / 4] : 'x;
            end
         end
         if (mgd) begin
            ma = d_req_addr;
            if (ma >= 4 * DEPTH) begin
               e_de = 1; e_dd = '0;
            end else if (d_req_we) begin
               e_de = 0; e_dd = '0;
               mo = mm.exists(ma / 4) ? mm[ma / 4] : '0;
               for (int k = 0; k < 4; k++)
                  if (d_req_be[k]) mo[8*k +: 8] = d_req_wdata[8*k +: 8];
               if (d_req_be != 0) mm[ma / 4] = mo;
            end else begin
               e_de = 0;
               e_dd = mm.exists(ma / 4) ? mm[ma / 4] : 'x;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("i_ready", {63'd0, i_req_ready}, {63'd0, m_gi()});
      chk("d_ready", {63'd0, d_req_ready}, {63'd0, m_gd()});
      chk("i_valid", {63'd0, i_rsp_valid}, {63'd0, e_iv});
      chk("i_err",   {63'd0, i_rsp_err},   {63'd0, e_ie});
      chk("i_data",  {32'd0, i_rsp_data},  {32'd0, e_id});
      chk("d_valid", {63'd0, d_rsp_valid}, {63'd0, e_dv});
      chk("d_err",   {63'd0, d_rsp_err},   {63'd0, e_de});
      chk("d_rdata", {32'd0, d_rsp_rdata}, {32'd0, e_dd});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_req_valid = 0;
      d_req_valid = 0;
      d_req_we    = 0;
      d_req_be    = '0;
   endtask

   task automatic dwr(input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
      d_req_valid = 1; d_req_we = 1;
      d_req_be = be; d_req_addr = a; d_req_wdata = wd;
   endtask

   task automatic drd(input logic [31:0] a);
      d_req_valid = 1; d_req_we = 0; d_req_be = '0; d_req_addr = a;
   endtask

   task automatic ird(input logic [31:0] a);
      i_req_valid = 1; i_req_addr = a;
   endtask

   int ngr;

   initial begin
      repeat (2) step();
      i_req_valid = 1; d_req_valid = 1;
      #1;
      chk("rst_i_ready", {63'd0, i_req_ready}, 64'd0);
      chk("rst_d_ready", {63'd0, d_req_ready}, 64'd0);
      chk("rst_d_valid", {63'd0, d_rsp_valid}, 64'd0);
      chk("rst_i_data",  {32'd0, i_rsp_data},  64'd0);
      idle();
      step();
      rst = 0;

      dwr(32'h10, 4'hF, 32'hDEADBEEF); step();
      chk("w1_ack", {63'd0, d_rsp_valid}, 64'd1);
      idle(); ird(32'h10); step();
      chk("ird_valid", {63'd0, i_rsp_valid}, 64'd1);
      chk("ird_data",  {32'd0, i_rsp_data},  64'hDEADBEEF);
      chk("ird_err",   {63'd0, i_rsp_err},   64'd0);

      idle(); dwr(32'h10, 4'b0010, 32'h0000AA00); step();
      idle(); drd(32'h10); step();
      chk("be_merge", {32'd0, d_rsp_rdata}, 64'hDEADAAEF);

      idle(); ird(32'h10); drd(32'h10); #1;
      chk("both_d_ready", {63'd0, d_req_ready}, 64'd1);
      chk("both_i_ready", {63'd0, i_req_ready}, 64'd0);
      step();
      chk("both_d_rsp", {63'd0, d_rsp_valid}, 64'd1);
      chk("both_i_rsp", {63'd0, i_rsp_valid}, 64'd0);
      idle(); step();

      ird(32'h10); drd(32'h10);
      ngr = 0;
      repeat (20) begin
         @(negedge clk);
         if (i_req_valid && i_req_ready) ngr++;
         @(posedge clk); #1;
      end
`ifdef CCM_STARVE_GUARD_EN
      chk("starve_grants", 64'(ngr), 64'd4);
`else
      chk("starve_grants", 64'(ngr), 64'd0);
`endif
      idle(); step();

      ird(32'h0000_4000); step();
      chk("i_oor_err",  {63'd0, i_rsp_err},  64'd1);
      chk("i_oor_data", {32'd0, i_rsp_data}, 64'd0);
      ird(32'h2); step();
      chk("i_mis_err",  {63'd0, i_rsp_err},  64'd1);
      chk("i_mis_data", {32'd0, i_rsp_data}, 64'd0);
      ird(32'h10); step();
      chk("i_ok_err",  {63'd0, i_rsp_err},  64'd0);
      chk("i_ok_data", {32'd0, i_rsp_data}, 64'hDEADAAEF);
      idle(); drd(32'h0000_4000); step();
      chk("d_oor_err", {63'd0, d_rsp_err}, 64'd1);

      dwr(32'h0, 4'hF, 32'h12345678); step();
      dwr(32'h0000_4000, 4'hF, 32'hFFFFFFFF); step();
      chk("d_oor_werr", {63'd0, d_rsp_err}, 64'd1);
      drd(32'h0); step();
      chk("no_alias", {32'd0, d_rsp_rdata}, 64'h12345678);
      drd(32'h13); step();
      chk("d_lsb_ign", {32'd0, d_rsp_rdata}, 64'hDEADAAEF);

      dwr(32'h10, 4'h0, 32'h0); step();
      chk("be0_err", {63'd0, d_rsp_err}, 64'd0);
      drd(32'h10); step();
      chk("be0_keep", {32'd0, d_rsp_rdata}, 64'hDEADAAEF);

      dwr(32'h20, 4'hF, 32'hA5A55A5A); step();
      drd(32'h20); step();
      chk("raw1", {32'd0, d_rsp_rdata}, 64'hA5A55A5A);
      dwr(32'h20, 4'b1000, 32'h11000000); step();
      drd(32'h20); step();
      chk("raw2", {32'd0, d_rsp_rdata}, 64'h11A55A5A);
      dwr(32'h24, 4'hF, 32'hCAFEF00D); step();
      idle(); ird(32'h24); step();
      chk("raw_i", {32'd0, i_rsp_data}, 64'hCAFEF00D);
      idle(); step();
      chk("hold_valid", {63'd0, i_rsp_valid}, 64'd0);
      chk("hold_data",  {32'd0, i_rsp_data},  64'hCAFEF00D);

      drd(32'h10); step();
      rst = 1; idle(); #1;
      chk("abort_valid", {63'd0, d_rsp_valid}, 64'd0);
      chk("abort_rdata", {32'd0, d_rsp_rdata}, 64'd0);
      chk("abort_i_dat", {32'd0, i_rsp_data},  64'd0);
      step();
      rst = 0;
      step();
      chk("post_valid", {63'd0, d_rsp_valid}, 64'd0);
      chk("post_err",   {63'd0, d_rsp_err},   64'd0);
      drd(32'h10); step();
      chk("mem_kept", {32'd0, d_rsp_rdata}, 64'hDEADAAEF);
      idle(); repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
